// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two prioritised
// write ports with bypass, a req/ack debug port and a post-reset clear sequencer.
module regfile_mp #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    parameter int  NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we0_i,
    input  logic [AW-1:0]       waddr0_i,
    input  logic [XLEN-1:0]     wdata0_i,
    input  logic                we1_i,
    input  logic [AW-1:0]       waddr1_i,
    input  logic [XLEN-1:0]     wdata1_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    input  logic                dbg_req_i,
    input  logic                dbg_we_i,
    input  logic [AW-1:0]       dbg_addr_i,
    input  logic [XLEN-1:0]     dbg_wdata_i,
    output logic                dbg_ack_o,
    output logic [XLEN-1:0]     dbg_rdata_o,
    output logic                init_done_o
);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {D_IDLE, D_ACK} dstate_t;

    state_t          state, state_nxt;
    dstate_t         dstate, dstate_nxt;
    logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
    logic [XLEN-1:0] dbg_rdata_nxt;
    logic [XLEN-1:0] regs [NREGS];

    logic run;
    logic grant;
    logic dbg_wr;
    logic wr0;
    logic wr1;

    // State register for both FSMs, the clear counter and the debug read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            dstate      <= D_IDLE;
            clr_cnt     <= '0;
            dbg_rdata_o <= '0;
        end else begin
            state       <= state_nxt;
            dstate      <= dstate_nxt;
            clr_cnt     <= clr_cnt_nxt;
            dbg_rdata_o <= dbg_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        dstate_nxt    = dstate;
        dbg_rdata_nxt = dbg_rdata_o;
        case (state)
            INIT: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == AW'(NREGS - 1))
                    state_nxt = RUN;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
        case (dstate)
            D_IDLE: begin
                if (grant) begin
                    dstate_nxt = D_ACK;
                    if (dbg_addr_i == '0)
                        dbg_rdata_nxt = '0;
                    else if (dbg_we_i)
                        dbg_rdata_nxt = dbg_wdata_i;
                    else
                        dbg_rdata_nxt = regs[dbg_addr_i];
                end
            end
            D_ACK:   dstate_nxt = D_IDLE;
            default: dstate_nxt = D_IDLE;
        endcase
    end

    always_comb begin
        run         = (state == RUN);
        grant       = run && (dstate == D_IDLE) && dbg_req_i && !we0_i && !we1_i;
        dbg_wr      = grant && dbg_we_i && (dbg_addr_i != '0);
        wr0         = run && we0_i && (waddr0_i != '0);
        wr1         = run && we1_i && (waddr1_i != '0);
        init_done_o = run;
        dbg_ack_o   = (dstate == D_ACK);
    end

    // Storage: the clear sweep and all writers are mutually exclusive except the
    // two core ports, where port 1 wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                regs[clr_cnt] <= '0;
            end else begin
                if (wr0 && !(wr1 && (waddr1_i == waddr0_i)))
                    regs[waddr0_i] <= wdata0_i;
                if (wr1)
                    regs[waddr1_i] <= wdata1_i;
                if (dbg_wr)
                    regs[dbg_addr_i] <= dbg_wdata_i;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        always_comb begin
            addr = raddr_i[k*AW +: AW];
            if (!run || (addr == '0))
                data = '0;
            else if (we1_i && (waddr1_i == addr))
                data = wdata1_i;
            else if (we0_i && (waddr0_i == addr))
                data = wdata0_i;
            else if (dbg_wr && (dbg_addr_i == addr))
                data = dbg_wdata_i;
            else
                data = regs[addr];
        end

        assign rdata_o[k*XLEN +: XLEN] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// checked against a behavioural model of the register bank and debug handshake.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst;
    logic                we0, we1;
    logic [AW-1:0]       waddr0, waddr1;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                dbg_req, dbg_we;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_wdata;
    logic                dbg_ack;
    logic [XLEN-1:0]     dbg_rdata;
    logic                init_done;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_run  = 1'b0;
    int              m_cnt  = 0;
    bit              m_ack  = 1'b0;
    logic [XLEN-1:0] m_drdata = '0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst(rst),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .raddr_i(raddr), .rdata_o(rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
        .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic bit m_grant();
        return m_run && !m_ack && dbg_req && !we0 && !we1;
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        if (!m_run || a == 0) return '0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        if (m_grant() && dbg_we && dbg_addr == a) return dbg_wdata;
        return m_regs[a];
    endfunction

    // Advance one clock, applying the register-file rules to the model
    task automatic tick();
        bit g;
        g = m_grant();
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_ack = 1'b0; m_drdata = '0;
        end else if (!m_run) begin
            m_regs[m_cnt] = '0;
            if (m_cnt == NREGS - 1) m_run = 1'b1;
            m_cnt++;
            m_ack = 1'b0;
        end else begin
            if (g) begin
                if (dbg_addr == 0) m_drdata = '0;
                else if (dbg_we) begin
                    m_regs[dbg_addr] = dbg_wdata;
                    m_drdata = dbg_wdata;
                end else m_drdata = m_regs[dbg_addr];
            end
            if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
            m_ack = g;
        end
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        raddr = '0;
        raddr[0 +: AW] = AW'(5);
        raddr[AW +: AW] = AW'(1);
        rst = 1;
        tick(); tick();
        #1;
        vectors++;
        if (init_done !== 1'b0) begin
            miscompares++; $display("FAIL reset_init_done: got %b expected 0", init_done);
        end
        vectors++;
        if (dbg_ack !== 1'b0) begin
            miscompares++; $display("FAIL reset_ack: got %b expected 0", dbg_ack);
        end
        vectors++;
        if (dbg_rdata !== '0) begin
            miscompares++; $display("FAIL reset_dbg_rdata: got %h expected 0", dbg_rdata);
        end
        vectors++;
        if (rdata !== '0) begin
            miscompares++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        rst = 0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < NREGS; i++) tick();
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++; $display("FAIL first_init_done: got %b expected 1", init_done);
        end
        we0 = 1; waddr0 = AW'(5); wdata0 = 32'hDEADBEEF;
        tick();
        we0 = 0;
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL preload_r5: got %h expected deadbeef", rdata[0 +: XLEN]);
        end
        rst = 1;
        tick();
        rst = 0;
        for (int i = 1; i <= NREGS; i++) begin
            #1;
            vectors++;
            if (rdata[0 +: XLEN] !== '0 || init_done !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_cycle_%0d: got rdata=%h init_done=%b expected rdata=0 init_done=0",
                         i, rdata[0 +: XLEN], init_done);
            end
            tick();
        end
        #1;
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++; $display("FAIL clear_done_edge: got %b expected 1", init_done);
        end
        vectors++;
        if (rdata[0 +: XLEN] !== '0) begin
            miscompares++; $display("FAIL clear_r5: got %h expected 0", rdata[0 +: XLEN]);
        end
    endtask

    task automatic test_collision();
        raddr[0 +: AW] = AW'(7);
        we0 = 1; waddr0 = AW'(7); wdata0 = 32'h11111111;
        we1 = 1; waddr1 = AW'(7); wdata1 = 32'h22222222;
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'h22222222) begin
            miscompares++; $display("FAIL collision_bypass: got %h expected 22222222", rdata[0 +: XLEN]);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'h22222222) begin
            miscompares++; $display("FAIL collision_stored: got %h expected 22222222", rdata[0 +: XLEN]);
        end
    endtask

    task automatic test_zero_reg();
        raddr[0 +: AW] = '0;
        raddr[AW +: AW] = '0;
        we0 = 1; waddr0 = '0; wdata0 = 32'hFFFFFFFF;
        we1 = 1; waddr1 = '0; wdata1 = 32'hFFFFFFFF;
        #1;
        vectors++;
        if (rdata !== '0) begin
            miscompares++; $display("FAIL zero_bypass: got %h expected 0", rdata);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (rdata !== '0) begin
            miscompares++; $display("FAIL zero_stored: got %h expected 0", rdata);
        end
        // Load a nonzero value into dbg_rdata first so the read of r0 is observable
        dbg_req = 1; dbg_we = 0; dbg_addr = AW'(7);
        tick();
        dbg_req = 0;
        #1;
        vectors++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h22222222) begin
            miscompares++; $display("FAIL dbg_read_r7: got ack=%b data=%h expected ack=1 data=22222222", dbg_ack, dbg_rdata);
        end
        tick();
        dbg_req = 1; dbg_addr = '0;
        tick();
        dbg_req = 0;
        #1;
        vectors++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== '0) begin
            miscompares++; $display("FAIL dbg_read_r0: got ack=%b data=%h expected ack=1 data=0", dbg_ack, dbg_rdata);
        end
        tick();
    endtask

    task automatic test_dbg_blocked();
        we1 = 1; waddr1 = AW'(3); wdata1 = 32'hA5A5A5A5;
        tick();
        we1 = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = AW'(3);
        we0 = 1; waddr0 = AW'(12);
        for (int i = 0; i < 3; i++) begin
            wdata0 = $urandom;
            tick();
            #1;
            vectors++;
            if (dbg_ack !== 1'b0) begin
                miscompares++; $display("FAIL blocked_ack_%0d: got %b expected 0", i, dbg_ack);
            end
        end
        we0 = 0;
        tick();
        dbg_req = 0;
        #1;
        vectors++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hA5A5A5A5) begin
            miscompares++; $display("FAIL blocked_grant: got ack=%b data=%h expected ack=1 data=a5a5a5a5", dbg_ack, dbg_rdata);
        end
        tick();
        #1;
        vectors++;
        if (dbg_ack !== 1'b0) begin
            miscompares++; $display("FAIL blocked_ack_drop: got %b expected 0", dbg_ack);
        end
    endtask

    task automatic test_dbg_write_bypass();
        raddr[AW +: AW] = AW'(9);
        dbg_req = 1; dbg_we = 1; dbg_addr = AW'(9); dbg_wdata = 32'h0BADF00D;
        #1;
        vectors++;
        if (rdata[XLEN +: XLEN] !== 32'h0BADF00D) begin
            miscompares++; $display("FAIL dbgwr_bypass: got %h expected 0badf00d", rdata[XLEN +: XLEN]);
        end
        tick();
        dbg_req = 0; dbg_we = 0;
        #1;
        vectors++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h0BADF00D) begin
            miscompares++; $display("FAIL dbgwr_ack: got ack=%b data=%h expected ack=1 data=0badf00d", dbg_ack, dbg_rdata);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            vectors++;
            if (dbg_ack !== 1'b0) begin
                miscompares++; $display("FAIL dbgwr_single_ack_%0d: got %b expected 0", i, dbg_ack);
            end
        end
        vectors++;
        if (rdata[XLEN +: XLEN] !== 32'h0BADF00D) begin
            miscompares++; $display("FAIL dbgwr_stored: got %h expected 0badf00d", rdata[XLEN +: XLEN]);
        end
    endtask

    task automatic test_reset_mid_access();
        we0 = 1; waddr0 = AW'(10); wdata0 = 32'hCAFEF00D;
        tick();
        we0 = 0;
        raddr[0 +: AW] = AW'(10);
        dbg_req = 1; dbg_we = 1; dbg_addr = AW'(10); dbg_wdata = 32'h12345678;
        rst = 1;
        tick();
        rst = 0;
        dbg_req = 0; dbg_we = 0;
        for (int i = 1; i <= NREGS; i++) begin
            #1;
            vectors++;
            if (dbg_ack !== 1'b0 || init_done !== 1'b0 || rdata[0 +: XLEN] !== '0) begin
                miscompares++;
                $display("FAIL midrst_cycle_%0d: got ack=%b init_done=%b rdata=%h expected 0 0 0",
                         i, dbg_ack, init_done, rdata[0 +: XLEN]);
            end
            tick();
        end
        #1;
        vectors++;
        if (init_done !== 1'b1 || dbg_ack !== 1'b0) begin
            miscompares++; $display("FAIL midrst_done: got init_done=%b ack=%b expected 1 0", init_done, dbg_ack);
        end
        vectors++;
        if (rdata[0 +: XLEN] !== '0) begin
            miscompares++; $display("FAIL midrst_r10: got %h expected 0", rdata[0 +: XLEN]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            we0       = ($urandom_range(0, 9) < 3);
            we1       = ($urandom_range(0, 9) < 3);
            waddr0    = AW'($urandom);
            waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom);
            wdata0    = $urandom;
            wdata1    = $urandom;
            raddr     = NRD*AW'($urandom);
            dbg_req   = ($urandom_range(0, 1) == 1);
            dbg_we    = ($urandom_range(0, 1) == 1);
            dbg_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            dbg_wdata = $urandom;
            #1;
            for (int k = 0; k < NRD; k++) begin
                vectors++;
                if (rdata[k*XLEN +: XLEN] !== exp_read(raddr[k*AW +: AW])) begin
                    miscompares++;
                    $display("FAIL rand_rdata%0d_step%0d: got %h expected %h",
                             k, n, rdata[k*XLEN +: XLEN], exp_read(raddr[k*AW +: AW]));
                end
            end
            vectors++;
            if (dbg_ack !== m_ack || dbg_rdata !== m_drdata || init_done !== m_run) begin
                miscompares++;
                $display("FAIL rand_ctrl_step%0d: got ack=%b drdata=%h init_done=%b expected ack=%b drdata=%h init_done=%b",
                         n, dbg_ack, dbg_rdata, init_done, m_ack, m_drdata, m_run);
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_collision();
        test_zero_reg();
        test_dbg_blocked();
        test_dbg_write_bypass();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file: the successor to the core's single-write, dual-read register bank. It provides a configurable number of combinational read ports and two prioritised write ports, both with same-cycle write-to-read bypass. It also has a req/ack debug access port that gets the bank only when the core is not writing, and a post-reset clear sequencer that zeroes every entry. It sits between the ID stage (read ports) and the EX/WB stages (write ports), with the debug port driven by the JTAG debug module.

## Interface
- XLEN, 32, register data width in bits
- NREGS, 32, number of registers (power of two, ≥4); entry 0 is hard-wired zero
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), register address width (derived, not overridden)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- we0_i  in  1  write enable, port 0 (older instruction)
- waddr0_i  in  AW  write address, port 0
- wdata0_i  in  XLEN  write data, port 0
- we1_i  in  1  write enable, port 1 (younger instruction, higher priority)
- waddr1_i  in  AW  write address, port 1
- wdata1_i  in  XLEN  write data, port 1
- raddr_i  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rdata_o  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
- dbg_req_i  in  1  debug access request, held until ack
- dbg_we_i  in  1  debug write (1) or read (0)
- dbg_addr_i  in  AW  debug register address
- dbg_wdata_i  in  XLEN  debug write data
- dbg_ack_o  out  1  one-cycle access-complete pulse
- dbg_rdata_o  out  XLEN  registered debug read data
- init_done_o  out  1  high once the clear sequence has completed

## Operation
- Top FSM has two states, INIT and RUN. Reset enters INIT and clears the counter clr_cnt to 0.
  - INIT: writes 0 to regs[clr_cnt] every cycle and increments clr_cnt. After writing entry NREGS-1 it moves to RUN.
  - RUN: normal operation. The FSM never returns to INIT without rst.
- While in INIT, all core write enables are ignored, every rdata_o port reads 0, and debug requests are not granted.
- Core writes, in RUN:
  - A write to address 0 is discarded.
  - If both ports write the same nonzero address, port 1's data is stored.
- Reads (combinational), per port:
  - Address 0 reads 0.
  - Otherwise, on a match with waddr1 while we1 is high, return wdata1.
  - Else, on a match with waddr0 while we0 is high, return wdata0.
  - Else, on a match with a debug write being granted this cycle, return dbg_wdata_i.
  - Else, return the stored value.
- Debug FSM has two states, D_IDLE and D_ACK.
  - Grant condition: state is RUN, debug FSM is in D_IDLE, dbg_req_i=1, and we0_i=0 and we1_i=0.
  - On grant: if dbg_we_i=1 and the address is nonzero, the register is written at that edge. dbg_rdata_o is loaded at the same edge: with dbg_wdata_i for a write to a nonzero address, with 0 for address 0, and with regs[dbg_addr_i] for a read. The FSM then moves to D_ACK.
  - D_ACK: dbg_ack_o=1 for exactly this one cycle, then the FSM returns to D_IDLE. dbg_req_i is ignored while in D_ACK.
  - A request that is not granted (core writing, or still in INIT) waits indefinitely. Core writes always take priority.
- Reset mid-operation, in any state: the FSM goes to INIT and D_IDLE, any pending debug access is dropped without an ack, and the contents are re-cleared.

## Timing
- Reset values: dbg_ack_o=0, dbg_rdata_o=0, init_done_o=0; rdata_o reads 0 throughout INIT.
- Clear sequence: INIT lasts NREGS cycles after the rst-deasserted edge. init_done_o rises on the edge at which the FSM enters RUN; with the defaults, that is the 32nd clock edge after the first edge with rst=0.
- Read latency is 0 cycles (combinational). A write is visible the same cycle through the bypass and from storage starting the next cycle.
- Debug latency:
  - With no core write pending, a request sampled at edge k is granted at edge k, and ack is high from edge k until edge k+1.
  - Each cycle in which a core write is active adds one cycle of delay.
  - Back-to-back accesses: a new request can be granted no earlier than the edge that ends D_ACK, giving at most one access every 2 cycles.
- All state updates occur on the rising edge of clk.

## Test plan
- Reset, then clear:
  - Pre-load regs[5]=0xDEADBEEF.
  - Pulse rst, then read address 5 during the 32 INIT cycles and after the sequence completes.
  - Required: every read returns 0; init_done_o rises at the 32nd edge after rst deasserts; regs[5]=0 afterwards.
- Dual write collision:
  - Same cycle: we0 writes 0x11111111 and we1 writes 0x22222222, both to address 7.
  - Required: the same-cycle read of address 7 returns 0x22222222, and the stored value is 0x22222222.
- Zero register:
  - Both ports write 0xFFFFFFFF to address 0.
  - Required: all read ports and a debug read of address 0 return 0.
- Debug blocked by the core:
  - Hold dbg_req (read of address 3, which holds 0xA5A5A5A5) while we0 is active for 3 consecutive cycles.
  - Required: no ack during those 3 cycles; ack arrives in the cycle after the first idle edge; dbg_rdata_o=0xA5A5A5A5.
- Debug write with read bypass:
  - In a cycle with the core idle, perform a debug write of 0x0BADF00D to address 9 while raddr port 1 = 9.
  - Required: rdata port 1 shows 0x0BADF00D that same cycle; ack pulses exactly once; dbg_rdata_o=0x0BADF00D.
- Reset mid-access:
  - Assert rst in the cycle a debug request is granted.
  - Required: dbg_ack_o stays 0; the register is cleared and init_done_o=0 until the INIT sequence finishes again.
